// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the ID/EX register, the execute ALU and the MEM stage.
// Latency: none; this is wiring only.
// Backpressure: in_ready/out_ready travel against in_valid/out_valid.
// Ports (slave = ALU view):
//   in_valid, ALU_OP, A, B, in_rd, out_ready  -> into the ALU
//   in_ready, out_valid, result, out_rd, zero, ovf  <- out of the ALU
interface alu_exec_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALU_OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [TAG_W-1:0] in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_rd;
  logic             zero;
  logic             ovf;

  // Pipeline side that issues ops and consumes results.
  modport master (
    output in_valid, ALU_OP, A, B, in_rd, out_ready,
    input  in_ready, out_valid, result, out_rd, zero, ovf
  );

  // The execute unit itself.
  modport slave (
    input  in_valid, ALU_OP, A, B, in_rd, out_ready,
    output in_ready, out_valid, result, out_rd, zero, ovf
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with an iterative 1-bit/cycle shifter for sll/srl.
// Latency: 1 cycle for logic/arith/compare/undefined ops; k+1 cycles for a shift by k>0.
// Backpressure: result held until out_ready; in_ready low while shifting or while a held result is stalled.
// Ports: clk, rst (sync, active-high), flush (sync abort), busy (high in SHIFT),
//        bus (alu_exec_unit_if.slave: operand/op/tag in, result/tag/zero/ovf out).
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             busy,
  alu_exec_unit_if.slave   bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SGT = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;     // shift accumulator, doubles as the result register
  logic [SHAMT_W-1:0] cnt_q, cnt_d;     // shifts still to apply
  logic               shr_q, shr_d;     // 1: logical right, 0: left
  logic [TAG_W-1:0]   rd_q, rd_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   sum, diff, alu_res, shift_step;
  logic               alu_ovf;
  logic [SHAMT_W-1:0] shamt;
  logic               long_shift;
  logic               accept;

  // Single-cycle datapath on the incoming operands.
  always_comb begin
    sum     = bus.A + bus.B;
    diff    = bus.A - bus.B;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALU_OP)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.A[MSB] != bus.B[MSB]) && (diff[MSB] != bus.A[MSB]);
      end
      OP_AND:         alu_res = bus.A & bus.B;
      OP_OR:          alu_res = bus.A | bus.B;
      OP_XOR:         alu_res = bus.A ^ bus.B;
      OP_NOR:         alu_res = ~(bus.A | bus.B);
      // Only reached here with a zero shift amount; longer shifts go through SHIFT.
      OP_SLL, OP_SRL: alu_res = bus.A;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_SGT:         alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) > $signed(bus.B)};
      default:        alu_res = '0;
    endcase
  end

  assign shamt      = bus.B[SHAMT_W-1:0];
  assign long_shift = ((bus.ALU_OP == OP_SLL) || (bus.ALU_OP == OP_SRL)) && (shamt != '0);
  assign shift_step = shr_q ? (acc_q >> 1) : (acc_q << 1);

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == OUT) && bus.out_ready);
  // flush wins over a simultaneous in_valid.
  assign accept        = bus.in_valid && bus.in_ready && !flush;
  assign bus.out_valid = (state_q == OUT);
  assign busy          = (state_q == SHIFT);
  assign bus.result    = acc_q;
  assign bus.out_rd    = rd_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shr_d   = shr_q;
    rd_d    = rd_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    case (state_q)
      SHIFT: begin
        acc_d = shift_step;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = OUT;
          zero_d  = (shift_step == '0);
        end
      end
      IDLE, OUT: begin
        // A delivered result frees the slot; an accept in the same cycle refills it.
        if ((state_q == OUT) && bus.out_ready) state_d = IDLE;
        if (accept) begin
          rd_d = bus.in_rd;
          if (long_shift) begin
            state_d = SHIFT;
            acc_d   = bus.A;
            cnt_d   = shamt;
            shr_d   = (bus.ALU_OP == OP_SRL);
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            state_d = OUT;
            acc_d   = alu_res;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_ovf;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      shr_q   <= 1'b0;
      rd_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shr_q   <= shr_d;
      rd_q    <= rd_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed literal cases followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  alu_exec_unit_if #(.WIDTH(32), .TAG_W(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one slot that is either empty, still shifting (m_left > 0) or holding a result.
  bit          m_have;
  int          m_left;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  bit          m_zero;
  bit          m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of each code, using wide signed arithmetic for overflow.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output bit ovf);
    longint sa, sb, s;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 32'h0;
    ovf = 1'b0;
    case (op)
      4'd0: begin res = a + b; s = sa + sb; ovf = (s != longint'($signed(res))); end
      4'd1: begin res = a - b; s = sa - sb; ovf = (s != longint'($signed(res))); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~(a | b);
      4'd6: res = a << b[4:0];
      4'd7: res = a >> b[4:0];
      4'd8: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: res = (sa > sb) ? 32'd1 : 32'd0;
      default: res = 32'h0;
    endcase
  endfunction

  task automatic model_update();
    bit          acc;
    logic [31:0] r;
    bit          o;
    if (rst) begin
      m_have = 0; m_left = 0; m_res = '0; m_rd = '0; m_zero = 0; m_ovf = 0;
    end else if (flush) begin
      m_have = 0; m_left = 0;
    end else begin
      acc = bus.in_valid && (m_left == 0) && (!m_have || bus.out_ready);
      if (m_left > 0) m_left--;
      else if (m_have && bus.out_ready) m_have = 0;
      if (acc) begin
        ref_op(bus.ALU_OP, bus.A, bus.B, r, o);
        m_have = 1;
        m_res  = r;
        m_ovf  = o;
        m_zero = (r == 32'h0);
        m_rd   = bus.in_rd;
        m_left = ((bus.ALU_OP == 4'd6) || (bus.ALU_OP == 4'd7)) ? int'(bus.B[4:0]) : 0;
      end
    end
  endtask

  task automatic compare();
    bit exp_ov;
    exp_ov = m_have && (m_left == 0);
    check("in_ready",  32'(bus.in_ready),  32'((m_left == 0) && (!m_have || bus.out_ready)));
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check("busy",      32'(busy),          32'(m_left > 0));
    if (exp_ov) begin
      check("result", bus.result,       m_res);
      check("out_rd", 32'(bus.out_rd),  32'(m_rd));
      check("zero",   32'(bus.zero),    32'(m_zero));
      check("ovf",    32'(bus.ovf),     32'(m_ovf));
    end
  endtask

  // One clock: compare away from the edge, then advance the model with the inputs seen at the edge.
  task automatic step();
    @(negedge clk);
    #1;
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.ALU_OP   = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_rd    = rd;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!bus.out_valid && n < max) begin
      step();
      n++;
    end
    if (!bus.out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_valid: timed out after %0d cycles, expected out_valid", n);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.ALU_OP = 4'd0; bus.A = '0; bus.B = '0; bus.in_rd = '0;
    m_have = 0; m_left = 0; m_res = '0; m_rd = '0; m_zero = 0; m_ovf = 0;
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_result",    bus.result,         32'd0);
    check("rst_out_rd",    32'(bus.out_rd),    32'd0);
    check("rst_zero",      32'(bus.zero),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);

    // add overflow.
    issue(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd1);
    wait_valid(2, n);
    check("add_lat",  n,                 0);
    check("add_res",  bus.result,        32'h8000_0000);
    check("add_ovf",  32'(bus.ovf),      32'd1);
    check("add_zero", 32'(bus.zero),     32'd0);

    // sub to zero.
    issue(4'd1, 32'd5, 32'd5, 5'd3);
    wait_valid(2, n);
    check("sub_lat",  n,                 0);
    check("sub_res",  bus.result,        32'd0);
    check("sub_zero", 32'(bus.zero),     32'd1);
    check("sub_ovf",  32'(bus.ovf),      32'd0);
    check("sub_rd",   32'(bus.out_rd),   32'd3);

    // sub overflow at the negative boundary.
    issue(4'd1, 32'h8000_0000, 32'd1, 5'd4);
    check("subo_res", bus.result,        32'h7FFF_FFFF);
    check("subo_ovf", 32'(bus.ovf),      32'd1);

    // sll by 4: 4 busy cycles, result on the 5th.
    issue(4'd6, 32'd1, 32'd4, 5'd7);
    check("sll_busy",  32'(busy),        32'd1);
    check("sll_inrdy", 32'(bus.in_ready), 32'd0);
    wait_valid(40, n);
    check("sll_cycles", n,               4);
    check("sll_res",    bus.result,      32'h0000_0010);

    // srl by 31.
    issue(4'd7, 32'h8000_0000, 32'd31, 5'd8);
    wait_valid(40, n);
    check("srl_cycles", n,               31);
    check("srl_res",    bus.result,      32'h0000_0001);

    // Back-to-back and/or/xor.
    bus.out_ready = 1'b1;
    bus.A = 32'hF0F0_F0F0; bus.B = 32'hFF00_FF00; bus.in_rd = 5'd10;
    bus.in_valid = 1'b1;
    bus.ALU_OP = 4'd2; step();
    check("b2b_and_v", 32'(bus.out_valid), 32'd1);
    check("b2b_and",   bus.result,         32'hF000_F000);
    bus.ALU_OP = 4'd3; step();
    check("b2b_or_v",  32'(bus.out_valid), 32'd1);
    check("b2b_or",    bus.result,         32'hFFF0_FFF0);
    bus.ALU_OP = 4'd4; step();
    check("b2b_xor_v", 32'(bus.out_valid), 32'd1);
    check("b2b_xor",   bus.result,         32'h0FF0_0FF0);

    // Stall on the second result.
    bus.ALU_OP = 4'd2; step();
    bus.ALU_OP = 4'd3; step();
    bus.out_ready = 1'b0;
    bus.ALU_OP = 4'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_res",   bus.result,        32'hFFF0_FFF0);
      check("hold_inrdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    check("release_res", bus.result, 32'h0FF0_0FF0);
    bus.in_valid = 1'b0;
    step();

    // Signed compares and an undefined code.
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd11);
    check("slt_res", bus.result, 32'd1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd12);
    check("sgt_res", bus.result, 32'd0);
    issue(4'd12, 32'd5, 32'd3, 5'd13);
    check("undef_res", bus.result,   32'd0);
    check("undef_ovf", 32'(bus.ovf), 32'd0);

    // flush mid-shift with in_valid high, then the next op goes in.
    issue(4'd6, 32'd3, 32'd10, 5'd9);
    step();
    flush = 1'b1;
    bus.ALU_OP = 4'd0; bus.A = 32'd1; bus.B = 32'd2; bus.in_rd = 5'd14; bus.in_valid = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ov",    32'(bus.out_valid), 32'd0);
    check("flush_busy",  32'(busy),          32'd0);
    check("flush_inrdy", 32'(bus.in_ready),  32'd1);
    step();
    bus.in_valid = 1'b0;
    check("postflush_v",   32'(bus.out_valid), 32'd1);
    check("postflush_res", bus.result,         32'd3);

    // flush of a held result beats a valid input.
    bus.in_valid = 1'b1; bus.ALU_OP = 4'd3; flush = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_out_v", 32'(bus.out_valid), 32'd0);
    step();
    check("flush_noacc", 32'(bus.out_valid), 32'd0);

    // Reset mid-shift.
    issue(4'd6, 32'd1, 32'd10, 5'd15);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_ov",    32'(bus.out_valid), 32'd0);
    check("rstmid_busy",  32'(busy),          32'd0);
    check("rstmid_res",   bus.result,         32'd0);
    check("rstmid_inrdy", 32'(bus.in_ready),  32'd1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.out_ready = ($urandom_range(0, 99) < 75);
      flush         = ($urandom_range(0, 99) < 3);
      rst           = ($urandom_range(0, 199) == 0);
      bus.ALU_OP    = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       bus.A = 32'h7FFF_FFFF;
        1:       bus.A = 32'h8000_0000;
        default: bus.A = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       bus.B = 32'($urandom_range(0, 6));
        1:       bus.B = (bus.ALU_OP == 4'd1) ? bus.A : 32'hFFFF_FFFF;
        default: bus.B = $urandom;
      endcase
      bus.in_rd = 5'($urandom_range(0, 31));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
